// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute stage with valid/ready handshakes on both sides.
// Most ops finish in one cycle; shifts iterate one bit position per cycle.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   // state | meaning
   // IDLE  | waiting for an operation, in_ready high
   // SHIFT | iterating a shift, one bit position per cycle
   // DONE  | result presented, waiting for out_ready
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_n;
   logic [XLEN-1:0]      result_q, result_n;
   logic                 illegal_q, illegal_n;
   logic [SHAMT_W-1:0]   cnt_q, cnt_n;
   logic [1:0]           shop_q, shop_n;

   logic [XLEN-1:0]      alu_res;
   logic                 alu_ill;
   logic                 is_shift;
   logic [XLEN-1:0]      shift_res;
   logic [SHAMT_W-1:0]   shamt;

   assign shamt = op_b[SHAMT_W-1:0];

   always_comb begin
      alu_res  = '0;
      alu_ill  = 1'b0;
      is_shift = 1'b0;
      case (alu_ctrl)
         4'b0000: alu_res = op_a + op_b;
         4'b0001: alu_res = op_a - op_b;
         4'b0010: alu_res = op_a & op_b;
         4'b0011: alu_res = op_a | op_b;
         4'b0100: alu_res = op_a ^ op_b;
         4'b0101, 4'b0110, 4'b0111: begin
            alu_res  = op_a;
            is_shift = 1'b1;
         end
         4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b1001: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: alu_ill = 1'b1;
      endcase
   end

   // shop_q holds alu_ctrl[1:0] of the accepted shift: 01 SLL, 10 SRL, 11 SRA
   always_comb begin
      shift_res = result_q;
      case (shop_q)
         2'b01:   shift_res = {result_q[XLEN-2:0], 1'b0};
         2'b10:   shift_res = {1'b0, result_q[XLEN-1:1]};
         2'b11:   shift_res = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default: shift_res = result_q;
      endcase
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign illegal   = illegal_q;
   assign zero      = (result_q == '0);

   always_comb begin
      state_n   = state_q;
      result_n  = result_q;
      illegal_n = illegal_q;
      cnt_n     = cnt_q;
      shop_n    = shop_q;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  result_n  = alu_res;
                  illegal_n = alu_ill;
                  shop_n    = alu_ctrl[1:0];
                  if (is_shift && (shamt != '0)) begin
                     cnt_n   = shamt;
                     state_n = SHIFT;
                  end else begin
                     state_n = DONE;
                  end
               end
            end
            SHIFT: begin
               result_n = shift_res;
               cnt_n    = cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) state_n = DONE;
            end
            DONE: begin
               if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
         shop_q    <= '0;
      end else begin
         state_q   <= state_n;
         result_q  <= result_n;
         illegal_q <= illegal_n;
         cnt_q     <= cnt_n;
         shop_q    <= shop_n;
      end
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width (log2 XLEN).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port alu_ctrl  input  4  operation code from the ALU control unit.
REQ-008 SHALL have port op_a  input  XLEN  operand A (rs1).
REQ-009 SHALL have port op_b  input  XLEN  operand B (rs2 or immediate); shift amount = op_b[SHAMT_W-1:0].
REQ-010 SHALL have port flush  input  1  squash in-flight operation (branch mispredict).
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port result  output  XLEN  operation result.
REQ-014 SHALL have port zero  output  1  result == 0, for branch decisions.
REQ-015 SHALL have port illegal  output  1  alu_ctrl not in supported set; qualified by out_valid.

Function
REQ-016 SHALL decode alu_ctrl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU; all others illegal.
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 SHALL accept an operation when in_valid && in_ready; in_ready = 1 only in IDLE and not in rst.
REQ-019 SHALL, for non-shift or illegal ops, compute result at acceptance and go IDLE -> DONE (out_valid asserted the cycle after acceptance, latency 1).
REQ-020 SHALL compute ADD/SUB modulo 2^XLEN, carries discarded; SLT signed, SLTU unsigned, result zero-extended 0/1.
REQ-021 SHALL treat illegal codes as result = 0, illegal = 1.
REQ-022 SHALL perform shifts iteratively, one bit position per cycle, in SHIFT, with a SHAMT_W-bit down-counter loaded with the shift amount.
REQ-023 SHALL go IDLE -> DONE directly for shift amount 0 (latency 1, result = op_a).
REQ-024 SHALL, for shift amount N > 0, assert out_valid N+1 cycles after acceptance; SRA replicates op_a[XLEN-1]; SLL/SRL fill zeros.
REQ-025 SHALL hold result, zero, illegal stable while out_valid && !out_ready.
REQ-026 SHALL go DONE -> IDLE on out_ready; no back-to-back acceptance in the same cycle (in_ready low in DONE).
REQ-027 SHALL, on flush, return to IDLE next cycle with out_valid = 0 from any state; flush has priority over acceptance and out_ready in the same cycle.
REQ-028 SHALL compute zero combinationally from the registered result.
REQ-029 SHALL ignore alu_ctrl/op_a/op_b changes outside the acceptance cycle.

Reset
REQ-030 SHALL, on rst high at a clock edge, enter IDLE with out_valid = 0, result = 0, zero = 1, illegal = 0, counter = 0; in_ready = 0 while rst is high.
REQ-031 SHALL abandon any in-progress shift or held result on rst; no output after reset release until a new acceptance.
REQ-032 SHALL give rst priority over flush and all handshakes.

Verification
REQ-033 SHALL verify ADD: op_a=0xFFFFFFFF, op_b=1, ctrl 0000 -> result 0, zero 1, out_valid 1 cycle after acceptance.
REQ-034 SHALL verify SUB/SLT/SLTU: op_a=0x00000001, op_b=0xFFFFFFFF -> SUB 0x00000002, SLT 0, SLTU 1.
REQ-035 SHALL verify SRA: op_a=0x80000000, op_b=4, ctrl 0111 -> result 0xF8000000, out_valid 5 cycles after acceptance; SRL same -> 0x08000000.
REQ-036 SHALL verify backpressure: out_ready held 0 for 3 cycles -> result/out_valid stable, in_ready 0; out_ready 1 -> IDLE, in_ready 1 next cycle.
REQ-037 SHALL verify flush at cycle 2 of SLL by 31 -> out_valid never asserts, in_ready 1 next cycle; likewise rst mid-shift -> reset values.
REQ-038 SHALL verify ctrl 1111 -> illegal 1, result 0, latency 1; shift amount 0 -> result = op_a, latency 1.
